// File: rtl/mul_pipe.sv
// Three-stage pipelined signed fixed-point multiplier with runtime rounding mode,
// optional saturation, a user sideband tag and a global-stall valid/ready handshake.
module mul_pipe #(
    parameter int WIDTH = 8,
    parameter int FBITS = 4,
    parameter int SAT   = 1,
    parameter int UW    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       rmode,
    input  logic [UW-1:0]    in_user,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] val,
    output logic             ovf,
    output logic [UW-1:0]    out_user
);

    localparam int PW = 2 * WIDTH;

    logic                    adv;
    logic                    v1, v2, v3;
    logic signed [WIDTH-1:0] a1, b1;
    logic [1:0]              rm1, rm2;
    logic [UW-1:0]           u1, u2;
    logic signed [PW-1:0]    ax, bx, prod_c, prod2;

    logic signed [PW-1:0]    q;
    logic [FBITS-1:0]        r, half;
    logic                    inc;
    logic signed [PW:0]      qr, maxv, minv;
    logic                    res_ovf;
    logic [WIDTH-1:0]        res_val;

    // Whole pipeline advances together; a bubble in S3 absorbs a stall.
    assign adv       = !v3 || out_ready;
    assign in_ready  = adv;
    assign out_valid = v3;

    assign ax     = {{WIDTH{a1[WIDTH-1]}}, a1};
    assign bx     = {{WIDTH{b1[WIDTH-1]}}, b1};
    assign prod_c = ax * bx;

    always_comb begin
        q    = prod2 >>> FBITS;
        r    = prod2[FBITS-1:0];
        half = '0;
        half[FBITS-1] = 1'b1;
        inc  = 1'b0;
        case (rm2)
            2'd0:    inc = 1'b0;
            2'd1:    inc = (r >= half);
            default: inc = (r > half) || ((r == half) && q[0]);
        endcase
        // One extra bit so the rounding increment can never wrap.
        qr   = {q[PW-1], q} + {{PW{1'b0}}, inc};
        maxv = '0;
        maxv[WIDTH-2:0] = '1;
        minv = '1;
        minv[WIDTH-2:0] = '0;
        res_ovf = (qr > maxv) || (qr < minv);
        if (res_ovf && (SAT != 0)) begin
            res_val = qr[PW] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            res_val = qr[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            val      <= '0;
            ovf      <= 1'b0;
            out_user <= '0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
            v3 <= v2;
            if (v2) begin
                val      <= res_val;
                ovf      <= res_ovf;
                out_user <= u2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            if (in_valid) begin
                a1  <= a;
                b1  <= b;
                rm1 <= rmode;
                u1  <= in_user;
            end
            if (v1) begin
                prod2 <= prod_c;
                rm2   <= rm1;
                u2    <= u1;
            end
        end
    end

endmodule

// File: tb/tb_mul_pipe.sv
// Scoreboard bench for mul_pipe: a saturating and a wrapping instance share stimulus,
// expected results are queued at issue and compared when the DUT emits them.
module tb_mul_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, w_in_ready;
    logic [7:0] a, b;
    logic [1:0] rmode;
    logic [3:0] in_user;
    logic       out_valid, w_out_valid, out_ready;
    logic [7:0] val, w_val;
    logic       ovf, w_ovf;
    logic [3:0] out_user, w_user;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mul_pipe #(.WIDTH(8), .FBITS(4), .SAT(1), .UW(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .rmode(rmode), .in_user(in_user),
        .out_valid(out_valid), .out_ready(out_ready), .val(val), .ovf(ovf),
        .out_user(out_user)
    );

    mul_pipe #(.WIDTH(8), .FBITS(4), .SAT(0), .UW(4)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .a(a), .b(b), .rmode(rmode), .in_user(in_user),
        .out_valid(w_out_valid), .out_ready(out_ready), .val(w_val), .ovf(w_ovf),
        .out_user(w_user)
    );

    typedef struct {
        logic [7:0] val;
        logic       ovf;
        logic [3:0] user;
        logic [7:0] wval;
        logic       wovf;
        int         t;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] rm;
        logic [7:0] val;
        logic       ovf;
        logic [7:0] wval;
    } vec_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Integer reference: {ovf, val} for Q4.4 operands.
    function automatic logic [8:0] ref_mul(input logic [7:0] x, input logic [7:0] y,
                                           input logic [1:0] rm, input bit sat);
        longint p, q, r, qr;
        bit inc, o;
        logic [7:0] v;
        p = longint'($signed(x)) * longint'($signed(y));
        q = p >>> 4;
        r = p - q * 16;
        case (rm)
            2'd0:    inc = 1'b0;
            2'd1:    inc = (r >= 8);
            default: inc = (r > 8) || ((r == 8) && (q % 2 != 0));
        endcase
        qr = q + longint'(inc);
        o  = (qr > 127) || (qr < -128);
        if (o && sat) v = (qr > 0) ? 8'h7F : 8'h80;
        else          v = qr[7:0];
        return {o, v};
    endfunction

    task automatic drive(input logic [7:0] x, input logic [7:0] y,
                         input logic [1:0] rm, input logic [3:0] u);
        a = x; b = y; rmode = rm; in_user = u; in_valid = 1'b1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; rmode = '0; in_user = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, val, ovf, out_user, w_out_valid, w_val, w_ovf} !== 23'd0) begin
            errors++;
            $display("FAIL reset_state: got valid=%b val=%h ovf=%b user=%h wvalid=%b wval=%h wovf=%b expected all zero",
                     out_valid, val, ovf, out_user, w_out_valid, w_val, w_ovf);
        end
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_basic;
        exp_t e;
        bit   seen;
        out_ready = 1'b1;
        @(posedge clk); #1 drive(8'h18, 8'h20, 2'd0, 4'h5);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_ready: got %b expected 1", in_ready);
        end
        e = '{8'h30, 1'b0, 4'h5, 8'h30, 1'b0, cyc};
        sb.push_back(e);
        @(posedge clk); #1 in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                checks++;
                if ({val, ovf, out_user, w_out_valid, w_val, w_ovf} !== {e.val, e.ovf, e.user, 1'b1, e.wval, e.wovf}) begin
                    errors++;
                    $display("FAIL basic_result: got val=%h ovf=%b user=%h wval=%h wovf=%b expected val=%h ovf=%b user=%h wval=%h wovf=%b",
                             val, ovf, out_user, w_val, w_ovf, e.val, e.ovf, e.user, e.wval, e.wovf);
                end
                checks++;
                if (cyc - e.t !== 3) begin
                    errors++;
                    $display("FAIL basic_latency: got %0d expected 3", cyc - e.t);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL basic_timeout: got no out_valid expected one result");
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_single: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_arith;
        localparam int N = 19;
        vec_t tv[N];
        exp_t e;
        tv[0]  = '{8'h01, 8'h08, 2'd0, 8'h00, 1'b0, 8'h00};
        tv[1]  = '{8'h01, 8'h08, 2'd1, 8'h01, 1'b0, 8'h01};
        tv[2]  = '{8'h01, 8'h08, 2'd2, 8'h00, 1'b0, 8'h00};
        tv[3]  = '{8'h03, 8'h08, 2'd3, 8'h02, 1'b0, 8'h02};
        tv[4]  = '{8'h03, 8'h08, 2'd0, 8'h01, 1'b0, 8'h01};
        tv[5]  = '{8'h03, 8'h08, 2'd1, 8'h02, 1'b0, 8'h02};
        tv[6]  = '{8'h03, 8'h08, 2'd2, 8'h02, 1'b0, 8'h02};
        tv[7]  = '{8'hFF, 8'h08, 2'd0, 8'hFF, 1'b0, 8'hFF};
        tv[8]  = '{8'hFF, 8'h08, 2'd1, 8'h00, 1'b0, 8'h00};
        tv[9]  = '{8'hFF, 8'h08, 2'd2, 8'h00, 1'b0, 8'h00};
        tv[10] = '{8'h7F, 8'h7F, 2'd0, 8'h7F, 1'b1, 8'hF0};
        tv[11] = '{8'h80, 8'h80, 2'd0, 8'h7F, 1'b1, 8'h00};
        tv[12] = '{8'h80, 8'h7F, 2'd0, 8'h80, 1'b1, 8'h08};
        tv[13] = '{8'h78, 8'h11, 2'd1, 8'h7F, 1'b1, 8'h80};
        tv[14] = '{8'h78, 8'h11, 2'd0, 8'h7F, 1'b0, 8'h7F};
        tv[15] = '{8'h05, 8'h08, 2'd2, 8'h02, 1'b0, 8'h02};
        tv[16] = '{8'h05, 8'h08, 2'd1, 8'h03, 1'b0, 8'h03};
        tv[17] = '{8'hFE, 8'h09, 2'd0, 8'hFE, 1'b0, 8'hFE};
        tv[18] = '{8'hFE, 8'h09, 2'd2, 8'hFF, 1'b0, 8'hFF};
        out_ready = 1'b1;
        for (int k = 0; k < N + 8; k++) begin
            @(posedge clk); #1;
            if (k < N) drive(tv[k].a, tv[k].b, tv[k].rm, 4'(k));
            else       in_valid = 1'b0;
            @(negedge clk);
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL arith_extra: got unexpected val=%h expected no output", val);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if ({val, ovf, out_user, w_out_valid, w_val, w_ovf} !== {e.val, e.ovf, e.user, 1'b1, e.wval, e.wovf}) begin
                        errors++;
                        $display("FAIL arith[%0d]: got val=%h ovf=%b wval=%h wovf=%b expected val=%h ovf=%b wval=%h wovf=%b (user got %h expected %h)",
                                 e.user, val, ovf, w_val, w_ovf, e.val, e.ovf, e.wval, e.wovf, out_user, e.user);
                    end
                    checks++;
                    if (cyc - e.t !== 3) begin
                        errors++;
                        $display("FAIL arith_latency[%0d]: got %0d expected 3", e.user, cyc - e.t);
                    end
                end
            end
            if (k < N) begin
                checks++;
                if (in_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL arith_ready[%0d]: got %b expected 1", k, in_ready);
                end
                e = '{tv[k].val, tv[k].ovf, 4'(k), tv[k].wval, tv[k].ovf, cyc};
                sb.push_back(e);
            end
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL arith_drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic test_back_to_back;
        localparam int N = 24;
        logic [7:0] x, y;
        logic [1:0] rm;
        logic [3:0] u;
        logic [8:0] rs, rw;
        logic       exp_rdy;
        bit         acc;
        int         dbud, cbud, got;
        exp_t       e, d;
        @(posedge clk);
        fork
            begin
                for (int i = 0; i < N; i++) begin
                    #1;
                    x  = 8'($urandom_range(0, 255));
                    y  = 8'($urandom_range(0, 255));
                    rm = 2'($urandom_range(0, 3));
                    u  = 4'($urandom_range(0, 15));
                    drive(x, y, rm, u);
                    acc = 1'b0;
                    dbud = 0;
                    while (!acc && dbud < 100) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk);
                        dbud++;
                    end
                    if (!acc) begin
                        checks++;
                        errors++;
                        $display("FAIL b2b_accept[%0d]: got in_ready stuck low expected acceptance", i);
                    end else begin
                        rs = ref_mul(x, y, rm, 1'b1);
                        rw = ref_mul(x, y, rm, 1'b0);
                        d  = '{rs[7:0], rs[8], u, rw[7:0], rw[8], 0};
                        sb.push_back(d);
                    end
                end
                #1 in_valid = 1'b0;
            end
            begin
                got = 0;
                cbud = 0;
                while (got < N && cbud < 600) begin
                    #1 out_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    exp_rdy = !(out_valid && !out_ready);
                    checks++;
                    if ({in_ready, w_in_ready} !== {exp_rdy, exp_rdy}) begin
                        errors++;
                        $display("FAIL b2b_in_ready: got %b/%b expected %b", in_ready, w_in_ready, exp_rdy);
                    end
                    if (out_valid === 1'b1 && out_ready === 1'b1) begin
                        if (sb.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL b2b_extra: got unexpected val=%h expected no output", val);
                        end else begin
                            e = sb.pop_front();
                            checks++;
                            if ({val, ovf, out_user, w_out_valid, w_val, w_ovf, w_user} !== {e.val, e.ovf, e.user, 1'b1, e.wval, e.wovf, e.user}) begin
                                errors++;
                                $display("FAIL b2b_result[%0d]: got val=%h ovf=%b user=%h wval=%h wovf=%b wuser=%h expected val=%h ovf=%b user=%h wval=%h wovf=%b",
                                         got, val, ovf, out_user, w_val, w_ovf, w_user, e.val, e.ovf, e.user, e.wval, e.wovf);
                            end
                        end
                        got++;
                    end
                    @(posedge clk);
                    cbud++;
                end
                checks++;
                if (got != N) begin
                    errors++;
                    $display("FAIL b2b_count: got %0d results expected %0d", got, N);
                end
            end
        join
        #1 out_ready = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: got pending=%0d out_valid=%b expected 0 0", sb.size(), out_valid);
            sb.delete();
        end
    endtask

    task automatic test_reset_midstream;
        exp_t e;
        bit   seen;
        out_ready = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3; i++) begin
            #1 drive(8'h18, 8'h20, 2'd0, 4'(i + 1));
            @(posedge clk);
        end
        #1 in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, in_ready, w_out_valid} !== 3'b101) begin
            errors++;
            $display("FAIL mid_stall: got out_valid=%b in_ready=%b wvalid=%b expected 1 0 1", out_valid, in_ready, w_out_valid);
        end
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, val, ovf, out_user, in_ready, w_out_valid, w_val, w_in_ready} !==
            {1'b0, 8'h00, 1'b0, 4'h0, 1'b1, 1'b0, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_state: got valid=%b val=%h ovf=%b user=%h in_ready=%b wval=%h expected 0 00 0 0 1 00",
                     out_valid, val, ovf, out_user, in_ready, w_val);
        end
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || w_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL mid_ghost[%0d]: got out_valid=%b user=%h expected 0", k, out_valid, out_user);
            end
        end
        @(posedge clk); #1 drive(8'h05, 8'h08, 2'd1, 4'hA);
        @(negedge clk);
        e = '{8'h03, 1'b0, 4'hA, 8'h03, 1'b0, cyc};
        sb.push_back(e);
        @(posedge clk); #1 in_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                seen = 1'b1;
                e = sb.pop_front();
                checks++;
                if ({val, ovf, out_user, w_val, w_ovf} !== {e.val, e.ovf, e.user, e.wval, e.wovf}) begin
                    errors++;
                    $display("FAIL mid_result: got val=%h ovf=%b user=%h wval=%h expected val=%h ovf=%b user=%h wval=%h",
                             val, ovf, out_user, w_val, e.val, e.ovf, e.user, e.wval);
                end
                checks++;
                if (cyc - e.t !== 3) begin
                    errors++;
                    $display("FAIL mid_latency: got %0d expected 3", cyc - e.t);
                end
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL mid_timeout: got no out_valid expected one result");
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_arith;
        test_back_to_back;
        test_reset_midstream;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1);
    end

endmodule
